// File: rtl/bcd_stopwatch_mux_pkg.sv
// ---------------------------------------------------------------------------
// bcd_stopwatch_mux_pkg
// Shared definitions for the BCD stopwatch with multiplexed 7-segment output:
//   - sw_state_t : stopwatch control state (IDLE, RUN, STOP)
//   - SEG_0..SEG_9 : active-low segment patterns, bit order g..a
//   - SEG_BLANK  : all segments off
// ---------------------------------------------------------------------------
package bcd_stopwatch_mux_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } sw_state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_stopwatch_mux_seg7_decode.sv
// ---------------------------------------------------------------------------
// seg7_decode
// Combinational BCD to 7-segment decoder, active-low outputs.
// Ports:
//   bcd     in  4  BCD digit (values 10..15 decode to blank)
//   pattern out 7  segment pattern, bit6..0 = g..a, 0 = segment lit
// ---------------------------------------------------------------------------
module seg7_decode
    import bcd_stopwatch_mux_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_BLANK;
        case (bcd)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_stopwatch_mux.sv
// ---------------------------------------------------------------------------
// bcd_stopwatch_mux
// Multi-digit BCD stopwatch with run/stop control, lap freeze and a
// time-multiplexed common-anode 7-segment display driver.
// Parameters:
//   NUM_DIGITS  number of BCD digits / anodes (2..8)
//   TICK_DIV    mclk cycles per count increment (>= 2)
//   SCAN_DIV    mclk cycles per display digit advance (>= 2)
//   DP_DIGIT    digit index whose decimal point is lit
// Ports:
//   mclk        in   1           system clock, rising edge
//   rst         in   1           synchronous active-high reset
//   start_stop  in   1           pulse: IDLE->RUN, RUN->STOP, STOP->RUN
//   clear       in   1           pulse: zero count/lap/overflow, go IDLE
//   lap         in   1           pulse: freeze / release the display
//   an          out  NUM_DIGITS  anode enables, active low, one-hot-low
//   seg         out  8           cathodes, active low, bit7 = dp, 6..0 = g..a
//   running     out  1           high while in RUN
//   overflow    out  1           sticky, set on all-9s -> all-0s wrap
// ---------------------------------------------------------------------------
module bcd_stopwatch_mux
    import bcd_stopwatch_mux_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 100000,
    parameter int SCAN_DIV   = 100000,
    parameter int DP_DIGIT   = 3
) (
    input  logic                  mclk,
    input  logic                  rst,
    input  logic                  start_stop,
    input  logic                  clear,
    input  logic                  lap,
    output logic [NUM_DIGITS-1:0] an,
    output logic [7:0]            seg,
    output logic                  running,
    output logic                  overflow
);

    localparam int CNT_W  = NUM_DIGITS * 4;
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int IDX_W  = $clog2(NUM_DIGITS);

    // Ripple BCD increment; the top bit of the result is the carry out of
    // the most significant digit, i.e. the all-9s wrap.
    function automatic logic [CNT_W:0] bcd_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] res;
        logic [3:0]       d;
        logic             carry;
        res   = '0;
        carry = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            d = v[i*4 +: 4];
            if (carry) begin
                if (d == 4'd9) begin
                    d = 4'd0;
                end else begin
                    d     = d + 4'd1;
                    carry = 1'b0;
                end
            end
            res[i*4 +: 4] = d;
        end
        return {carry, res};
    endfunction

    sw_state_t         state;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  lap_reg;
    logic              lap_hold;
    logic [CNT_W:0]    count_inc;
    logic [SCAN_W-1:0] scan_cnt;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  disp;
    logic [3:0]        digit_sel;
    logic [6:0]        pattern;

    // The prescaler only advances in RUN, so a stop keeps the partial interval.
    assign tick      = (state == RUN) && (tick_cnt == TICK_W'(TICK_DIV - 1));
    assign count_inc = bcd_inc(count);

    // ---- control / counting stage ----
    always_ff @(posedge mclk) begin
        if (rst) begin
            state    <= IDLE;
            running  <= 1'b0;
            tick_cnt <= '0;
            count    <= '0;
            lap_reg  <= '0;
            lap_hold <= 1'b0;
            overflow <= 1'b0;
        end else if (clear) begin
            // clear outranks start_stop, lap and tick in the same cycle
            state    <= IDLE;
            running  <= 1'b0;
            tick_cnt <= '0;
            count    <= '0;
            lap_reg  <= '0;
            lap_hold <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (start_stop) begin
                case (state)
                    IDLE, STOP: begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                    RUN: begin
                        state   <= STOP;
                        running <= 1'b0;
                    end
                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                endcase
            end

            if (state == RUN) begin
                tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
            end

            if (tick) begin
                count <= count_inc[CNT_W-1:0];
                if (count_inc[CNT_W]) begin
                    overflow <= 1'b1;
                end
            end

            // Release works from any state; capture only while running.
            if (lap) begin
                if (lap_hold) begin
                    lap_hold <= 1'b0;
                end else if (state == RUN) begin
                    lap_reg  <= count;
                    lap_hold <= 1'b1;
                end
            end
        end
    end

    // ---- display select ----
    assign disp = lap_hold ? lap_reg : count;

    always_comb begin
        digit_sel = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                digit_sel = disp[i*4 +: 4];
            end
        end
    end

    seg7_decode u_seg7_decode (
        .bcd     (digit_sel),
        .pattern (pattern)
    );

    // ---- scan / output register stage ----
    // an and seg are registered from idx, so they follow an index change
    // by one cycle.
    always_ff @(posedge mclk) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
            an       <= '1;
            seg      <= 8'hFF;
        end else begin
            if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                idx      <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end
            an  <= ~(NUM_DIGITS'(1) << idx);
            seg <= {(idx != IDX_W'(DP_DIGIT)), pattern};
        end
    end

endmodule

// File: tb/tb_bcd_stopwatch_mux.sv
module tb_bcd_stopwatch_mux;

    localparam int ND  = 4;
    localparam int TD  = 4;
    localparam int SD  = 2;
    localparam int DPD = 3;

    logic          mclk = 1'b0;
    logic          rst = 1'b1;
    logic          start_stop = 1'b0;
    logic          clear = 1'b0;
    logic          lap = 1'b0;
    logic [ND-1:0] an;
    logic [7:0]    seg;
    logic          running;
    logic          overflow;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string name;
        int    val;
    } exp_t;

    exp_t sb[$];

    always #5 mclk = ~mclk;

    bcd_stopwatch_mux #(
        .NUM_DIGITS (ND),
        .TICK_DIV   (TD),
        .SCAN_DIV   (SD),
        .DP_DIGIT   (DPD)
    ) dut (
        .mclk       (mclk),
        .rst        (rst),
        .start_stop (start_stop),
        .clear      (clear),
        .lap        (lap),
        .an         (an),
        .seg        (seg),
        .running    (running),
        .overflow   (overflow)
    );

    function automatic logic [6:0] ref_pat(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [3:0] seg_to_digit(input logic [6:0] p);
        for (int d = 0; d < 10; d++) begin
            if (p == ref_pat(d)) return 4'(d);
        end
        return 4'hF;
    endfunction

    // advance n rising edges, land 1 ns after the last one
    task automatic cyc(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    task automatic pulse(input bit s, input bit c, input bit l);
        start_stop = s;
        clear      = c;
        lap        = l;
        @(posedge mclk);
        #1;
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
    endtask

    // watch the scan for a bounded number of cycles and collect each digit
    task automatic read_display(output logic [15:0] digs, output logic [3:0] mask);
        digs = 16'hFFFF;
        mask = 4'h0;
        for (int k = 0; k < 16 && mask != 4'hF; k++) begin
            cyc(1);
            for (int i = 0; i < ND; i++) begin
                if (an === ~(4'b0001 << i)) begin
                    digs[i*4 +: 4] = seg_to_digit(seg[6:0]);
                    mask[i]        = 1'b1;
                end
            end
        end
    endtask

    task automatic push_count(input string nm, input int v);
        for (int i = 0; i < ND; i++) begin
            sb.push_back('{nm, (v / (10 ** i)) % 10});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(3);
        n_checks++;
        if (an !== 4'hF) begin n_fail++; $display("FAIL reset_an: got %b expected 1111", an); end
        n_checks++;
        if (seg !== 8'hFF) begin n_fail++; $display("FAIL reset_seg: got %h expected ff", seg); end
        n_checks++;
        if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b expected 0", running); end
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        rst = 1'b0;
    endtask

    task automatic test_scan();
        int seq [8] = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b0111, 4'b0111};
        for (int k = 0; k < 8; k++) sb.push_back('{"scan_an", seq[k]});
        for (int k = 0; k < 8; k++) begin
            exp_t e;
            logic exp_dp;
            cyc(1);
            e      = sb.pop_front();
            exp_dp = (e.val == 4'b0111) ? 1'b0 : 1'b1;
            n_checks++;
            if (an !== 4'(e.val)) begin
                n_fail++; $display("FAIL %s[%0d]: got %b expected %b", e.name, k, an, 4'(e.val));
            end
            n_checks++;
            if (seg[7] !== exp_dp) begin
                n_fail++; $display("FAIL scan_dp[%0d]: got %b expected %b", k, seg[7], exp_dp);
            end
            n_checks++;
            if (seg[6:0] !== 7'b1000000) begin
                n_fail++; $display("FAIL scan_idle_seg[%0d]: got %b expected 1000000", k, seg[6:0]);
            end
        end
    endtask

    task automatic test_count();
        logic [15:0] digs;
        logic [3:0]  mask;
        pulse(1, 0, 0);
        n_checks++;
        if (running !== 1'b1) begin n_fail++; $display("FAIL run_follow: got %b expected 1", running); end
        cyc(40);
        n_checks++;
        if (running !== 1'b1) begin n_fail++; $display("FAIL run_40: got %b expected 1", running); end
        pulse(1, 0, 0);
        n_checks++;
        if (running !== 1'b0) begin n_fail++; $display("FAIL stop_running: got %b expected 0", running); end
        push_count("count_10", 10);
        read_display(digs, mask);
        n_checks++;
        if (mask !== 4'hF) begin n_fail++; $display("FAIL count_10_scan: got mask %b expected 1111", mask); end
        for (int i = 0; i < ND; i++) begin
            exp_t e = sb.pop_front();
            n_checks++;
            if (int'(digs[i*4 +: 4]) !== e.val) begin
                n_fail++; $display("FAIL %s digit%0d: got %0d expected %0d", e.name, i, digs[i*4 +: 4], e.val);
            end
        end
    endtask

    task automatic test_carry();
        logic [15:0] digs;
        logic [3:0]  mask;
        pulse(0, 1, 0);
        pulse(1, 0, 0);
        cyc(99 * TD);
        pulse(1, 0, 0);
        push_count("count_99", 99);
        read_display(digs, mask);
        for (int i = 0; i < ND; i++) begin
            exp_t e = sb.pop_front();
            n_checks++;
            if (int'(digs[i*4 +: 4]) !== e.val) begin
                n_fail++; $display("FAIL %s digit%0d: got %0d expected %0d", e.name, i, digs[i*4 +: 4], e.val);
            end
        end
        // resume: prescaler kept its partial interval, so 3 edges finish it
        pulse(1, 0, 0);
        cyc(3);
        pulse(1, 0, 0);
        push_count("count_100", 100);
        read_display(digs, mask);
        for (int i = 0; i < ND; i++) begin
            exp_t e = sb.pop_front();
            n_checks++;
            if (int'(digs[i*4 +: 4]) !== e.val) begin
                n_fail++; $display("FAIL %s digit%0d: got %0d expected %0d", e.name, i, digs[i*4 +: 4], e.val);
            end
        end
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL carry_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_overflow();
        logic [15:0] digs;
        logic [3:0]  mask;
        pulse(0, 1, 0);
        pulse(1, 0, 0);
        cyc(9999 * TD);
        pulse(1, 0, 0);
        push_count("count_9999", 9999);
        read_display(digs, mask);
        for (int i = 0; i < ND; i++) begin
            exp_t e = sb.pop_front();
            n_checks++;
            if (int'(digs[i*4 +: 4]) !== e.val) begin
                n_fail++; $display("FAIL %s digit%0d: got %0d expected %0d", e.name, i, digs[i*4 +: 4], e.val);
            end
        end
        pulse(1, 0, 0);
        cyc(3);
        n_checks++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL wrap_overflow: got %b expected 1", overflow); end
        n_checks++;
        if (running !== 1'b1) begin n_fail++; $display("FAIL wrap_running: got %b expected 1", running); end
        pulse(1, 0, 0);
        push_count("count_wrap", 0);
        read_display(digs, mask);
        for (int i = 0; i < ND; i++) begin
            exp_t e = sb.pop_front();
            n_checks++;
            if (int'(digs[i*4 +: 4]) !== e.val) begin
                n_fail++; $display("FAIL %s digit%0d: got %0d expected %0d", e.name, i, digs[i*4 +: 4], e.val);
            end
        end
        pulse(1, 0, 0);
        cyc(3);
        pulse(1, 0, 0);
        push_count("count_after_wrap", 1);
        read_display(digs, mask);
        for (int i = 0; i < ND; i++) begin
            exp_t e = sb.pop_front();
            n_checks++;
            if (int'(digs[i*4 +: 4]) !== e.val) begin
                n_fail++; $display("FAIL %s digit%0d: got %0d expected %0d", e.name, i, digs[i*4 +: 4], e.val);
            end
        end
        n_checks++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_reset_midcount();
        logic [15:0] digs;
        logic [3:0]  mask;
        pulse(1, 0, 0);
        cyc(14);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        n_checks++;
        if (running !== 1'b0) begin n_fail++; $display("FAIL midrst_running: got %b expected 0", running); end
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL midrst_overflow: got %b expected 0", overflow); end
        cyc(8);
        push_count("midrst_count", 0);
        read_display(digs, mask);
        for (int i = 0; i < ND; i++) begin
            exp_t e = sb.pop_front();
            n_checks++;
            if (int'(digs[i*4 +: 4]) !== e.val) begin
                n_fail++; $display("FAIL %s digit%0d: got %0d expected %0d", e.name, i, digs[i*4 +: 4], e.val);
            end
        end
    endtask

    task automatic test_lap();
        logic [15:0] digs;
        logic [3:0]  mask;
        pulse(0, 1, 0);
        pulse(1, 0, 0);
        cyc(12 * TD);
        pulse(0, 0, 1);
        cyc(20);
        pulse(1, 0, 0);
        push_count("lap_frozen", 12);
        read_display(digs, mask);
        for (int i = 0; i < ND; i++) begin
            exp_t e = sb.pop_front();
            n_checks++;
            if (int'(digs[i*4 +: 4]) !== e.val) begin
                n_fail++; $display("FAIL %s digit%0d: got %0d expected %0d", e.name, i, digs[i*4 +: 4], e.val);
            end
        end
        // release in STOP; live count kept advancing underneath
        pulse(0, 0, 1);
        push_count("lap_release", 17);
        read_display(digs, mask);
        for (int i = 0; i < ND; i++) begin
            exp_t e = sb.pop_front();
            n_checks++;
            if (int'(digs[i*4 +: 4]) !== e.val) begin
                n_fail++; $display("FAIL %s digit%0d: got %0d expected %0d", e.name, i, digs[i*4 +: 4], e.val);
            end
        end
        // lap in STOP with no hold is ignored: after resuming the display stays live
        pulse(0, 0, 1);
        pulse(1, 0, 0);
        cyc(2);
        pulse(1, 0, 0);
        push_count("lap_ignored", 18);
        read_display(digs, mask);
        for (int i = 0; i < ND; i++) begin
            exp_t e = sb.pop_front();
            n_checks++;
            if (int'(digs[i*4 +: 4]) !== e.val) begin
                n_fail++; $display("FAIL %s digit%0d: got %0d expected %0d", e.name, i, digs[i*4 +: 4], e.val);
            end
        end
    endtask

    task automatic test_clear_priority();
        logic [15:0] digs;
        logic [3:0]  mask;
        pulse(0, 1, 0);
        pulse(1, 0, 0);
        cyc(10);
        pulse(1, 1, 0);
        n_checks++;
        if (running !== 1'b0) begin n_fail++; $display("FAIL clr_ss_running: got %b expected 0", running); end
        push_count("clr_ss_count", 0);
        read_display(digs, mask);
        for (int i = 0; i < ND; i++) begin
            exp_t e = sb.pop_front();
            n_checks++;
            if (int'(digs[i*4 +: 4]) !== e.val) begin
                n_fail++; $display("FAIL %s digit%0d: got %0d expected %0d", e.name, i, digs[i*4 +: 4], e.val);
            end
        end
        // clear and lap together at count 5: lap must not capture
        pulse(1, 0, 0);
        n_checks++;
        if (running !== 1'b1) begin n_fail++; $display("FAIL idle_to_run: got %b expected 1", running); end
        cyc(5 * TD);
        pulse(0, 1, 1);
        pulse(1, 0, 0);
        cyc(2 * TD);
        pulse(1, 0, 0);
        push_count("clr_lap_count", 2);
        read_display(digs, mask);
        for (int i = 0; i < ND; i++) begin
            exp_t e = sb.pop_front();
            n_checks++;
            if (int'(digs[i*4 +: 4]) !== e.val) begin
                n_fail++; $display("FAIL %s digit%0d: got %0d expected %0d", e.name, i, digs[i*4 +: 4], e.val);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_scan();
        test_count();
        test_carry();
        test_overflow();
        test_reset_midcount();
        test_lap();
        test_clear_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_stopwatch_mux.md
BCD_STOPWATCH_MUX -- requirements
Module: bcd_stopwatch_mux

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of BCD digits and display anodes (legal 2..8).
REQ-002 Parameter TICK_DIV, default 100000, mclk cycles per count increment (legal >= 2).
REQ-003 Parameter SCAN_DIV, default 100000, mclk cycles per display digit advance (legal >= 2).
REQ-004 Parameter DP_DIGIT, default 3, digit index whose decimal point is lit (legal 0..NUM_DIGITS-1).
REQ-005 The block SHALL use one clock and a synchronous, active-high reset, with ports named as below.
REQ-006 mclk  input  1  system clock; all state updates on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 start_stop  input  1  single-cycle pulse, pre-debounced; toggles run/stop.
REQ-009 clear  input  1  single-cycle pulse; zeroes the count.
REQ-010 lap  input  1  single-cycle pulse; freezes or releases the display.
REQ-011 an  output  NUM_DIGITS  anode enables, active low, one-hot-low.
REQ-012 seg  output  8  cathodes, active low; bit7 = dp, bits6..0 = g..a.
REQ-013 running  output  1  high while in state RUN.
REQ-014 overflow  output  1  sticky; set on wrap from all-9s to all-0s.

Function
REQ-015 The FSM SHALL have three states: IDLE (count zero, never started), RUN and STOP.
REQ-016 A start_stop pulse SHALL cause these transitions: IDLE->RUN, RUN->STOP, STOP->RUN. The new state takes effect on the next edge; running follows one cycle after the pulse.
REQ-017 The tick prescaler SHALL count only in RUN. It SHALL hold its value in STOP, so the partial interval is preserved. At TICK_DIV-1 it SHALL wrap to 0 and issue a one-cycle tick.
REQ-018 The count SHALL be NUM_DIGITS BCD digits, each 0..9. On tick, digit0 increments. Digit i increments only when digits 0..i-1 are all 9. Each digit wraps 9->0 in the same cycle. No digit shall ever hold 10..15.
REQ-019 On a tick with all digits at 9, the count SHALL become all zeros and overflow SHALL be set. Counting continues.
REQ-020 A clear pulse SHALL do all of the following: zero the count, prescaler, lap register, lap_hold and overflow; go to IDLE.
REQ-021 Clear SHALL take priority over start_stop, lap and tick in the same cycle.
REQ-022 A lap pulse in RUN with lap_hold=0 SHALL copy the count into the lap register and set lap_hold.
REQ-023 A lap pulse with lap_hold=1, in any state, SHALL clear lap_hold.
REQ-024 A lap pulse in IDLE or STOP with lap_hold=0 SHALL be ignored.
REQ-025 The count SHALL keep advancing while lap_hold=1.
REQ-026 The displayed value SHALL be the lap register when lap_hold=1, otherwise the live count.
REQ-027 The scan prescaler SHALL run continuously in every state and is independent of the tick prescaler. At SCAN_DIV-1 it SHALL advance the digit index, which wraps from NUM_DIGITS-1 to 0.
REQ-028 an and seg SHALL be registered and SHALL update in the cycle after the index change. The active anode is bit index low; all other anodes are high.
REQ-029 seg[6:0] SHALL be the decoded pattern for the selected displayed digit: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Any other value SHALL produce all-ones (blank).
REQ-030 seg[7] SHALL be 0 only when the index equals DP_DIGIT.

Reset
REQ-031 On rst high at a clock edge, the block SHALL reset to: state IDLE, count zero, lap register zero, lap_hold 0, both prescalers 0, digit index 0, an all ones, seg 8'hFF, running 0, overflow 0.
REQ-032 rst SHALL override all inputs and take effect mid-count with no residual tick.

Structure
REQ-033 The shared package SHALL hold the FSM state enumeration (IDLE, RUN, STOP) and the ten segment pattern constants plus the blank constant.
REQ-034 The segment decoder SHALL be a separate combinational sub-module, seg7_decode: 4-bit BCD in, 7-bit active-low pattern out.
REQ-035 The BCD counter, prescalers, FSM and scan mux SHALL reside in bcd_stopwatch_mux.

Verification (NUM_DIGITS=4, TICK_DIV=4, SCAN_DIV=2, DP_DIGIT=3)
REQ-036 Reset, then start_stop pulse, then 40 cycles -> running=1 and count 0010.
REQ-037 Preload to 0099 via ticks, then one more tick -> count 0100 and overflow=0.
REQ-038 Count 9999 plus one tick -> count 0000, overflow=1 and running=1.
REQ-039 In RUN at count 0012: lap, then 20 cycles -> display shows 0012 while the live count is 0017. Then lap -> display shows 0017.
REQ-040 RUN: start_stop and clear in the same cycle -> state IDLE, count 0000 and running=0.
REQ-041 Scan over 8 cycles -> an sequence 1110, 1101, 1011, 0111, with seg[7]=0 only on 0111. In IDLE, seg[6:0]=1000000 for all digits.
